// File: rtl/apb_rr_master_arbiter_if.sv
// Requester-side command/response bundle plus APB bus signals for apb_rr_master_arbiter.
// The master modport is the arbiter's view, the slave modport the surrounding environment's.
interface apb_rr_master_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      busy;
  logic                      PSEL;
  logic                      PENABLE;
  logic                      PWRITE;
  logic [ADDR_W-1:0]         PADDR;
  logic [DATA_W-1:0]         PWDATA;
  logic [DATA_W-1:0]         PRDATA;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, PRDATA,
    output req_ready, rsp_valid, rsp_rdata, busy, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, PRDATA,
    input  req_ready, rsp_valid, rsp_rdata, busy, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_rr_master_arbiter.sv
// APB master shared by NUM_REQ requesters: round-robin grant, SETUP/ACCESS transfer,
// registered one-cycle completion pulse with read data back to the owning requester.
module apb_rr_master_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
) (
  input logic                    PCLK,
  input logic                    PRESETn,
  apb_rr_master_arbiter_if.master bus
);
  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, idx_q, win, cand;
  logic               found, accept, hs;
  logic               wr_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q, rdata_q;
  logic [NUM_REQ-1:0] rsp_q, ready;

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(ptr_q) + k) % NUM_REQ);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign accept = (state_q != StSetup);
  assign hs     = accept && found;

  // Gated by reset so no grant is offered while the block is held in reset.
  always_comb begin
    ready = '0;
    if (hs && PRESETn) ready[win] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (hs) state_d = StSetup;
      StSetup:  state_d = StAccess;
      StAccess: state_d = hs ? StSetup : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= StIdle;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      idx_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        wr_q    <= bus.req_write[win];
        addr_q  <= bus.req_addr[int'(win) * ADDR_W +: ADDR_W];
        wdata_q <= bus.req_wdata[int'(win) * DATA_W +: DATA_W];
        idx_q   <= win;
        ptr_q   <= win;
      end
      // Completion uses the pre-capture idx/wr, so a back-to-back accept is safe.
      if (state_q == StAccess) begin
        rsp_q   <= NUM_REQ'(1) << idx_q;
        rdata_q <= wr_q ? '0 : bus.PRDATA;
      end else begin
        rsp_q <= '0;
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.PSEL      = (state_q != StIdle);
  assign bus.PENABLE   = (state_q == StAccess);
  assign bus.PWRITE    = wr_q;
  assign bus.PADDR     = addr_q;
  assign bus.PWDATA    = wdata_q;
endmodule

// File: tb/tb_apb_rr_master_arbiter.sv
// Bench for apb_rr_master_arbiter: 2- and 3-requester instances share one stimulus stream and
// are checked every cycle against a transaction-level model, plus directed scenario checks.
module tb_apb_rr_master_arbiter;
  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  always #5 PCLK = ~PCLK;

  logic [2:0]  v, w;
  logic [31:0] a  [3];
  logic [31:0] wd [3];
  logic [31:0] prd;

  int checks = 0;
  int errors = 0;

  apb_rr_master_arbiter_if #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32)) if0 ();
  apb_rr_master_arbiter_if #(.NUM_REQ(3), .ADDR_W(32), .DATA_W(32)) if1 ();

  assign if0.req_valid = v[1:0];
  assign if0.req_write = w[1:0];
  assign if0.req_addr  = {a[1], a[0]};
  assign if0.req_wdata = {wd[1], wd[0]};
  assign if0.PRDATA    = prd;
  assign if1.req_valid = v;
  assign if1.req_write = w;
  assign if1.req_addr  = {a[2], a[1], a[0]};
  assign if1.req_wdata = {wd[2], wd[1], wd[0]};
  assign if1.PRDATA    = prd;

  apb_rr_master_arbiter #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32)) u_dut0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .bus(if0)
  );
  apb_rr_master_arbiter #(.NUM_REQ(3), .ADDR_W(32), .DATA_W(32)) u_dut1 (
    .PCLK(PCLK), .PRESETn(PRESETn), .bus(if1)
  );

  // Model: in-flight transfer age (-1 none, 0 first bus cycle, 1 second), last owner, pending response.
  int          nreq  [2];
  int          m_ptr [2];
  int          m_age [2];
  int          m_idx [2];
  logic        m_w   [2];
  logic [31:0] m_addr[2];
  logic [31:0] m_wd  [2];
  logic [31:0] m_rd  [2];
  logic [2:0]  m_rsp [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ptr[d]  = nreq[d] - 1;
      m_age[d]  = -1;
      m_idx[d]  = 0;
      m_w[d]    = 1'b0;
      m_addr[d] = '0;
      m_wd[d]   = '0;
      m_rd[d]   = '0;
      m_rsp[d]  = '0;
    end
  endtask

  task automatic get_obs(input int d, output logic [2:0] rdy, output logic [2:0] rv,
                         output logic psel, output logic pen, output logic pw,
                         output logic bsy, output logic [31:0] pa, output logic [31:0] pwd,
                         output logic [31:0] rrd);
    if (d == 0) begin
      rdy = 3'(if0.req_ready); rv = 3'(if0.rsp_valid); psel = if0.PSEL; pen = if0.PENABLE;
      pw = if0.PWRITE; bsy = if0.busy; pa = if0.PADDR; pwd = if0.PWDATA; rrd = if0.rsp_rdata;
    end else begin
      rdy = if1.req_ready; rv = if1.rsp_valid; psel = if1.PSEL; pen = if1.PENABLE;
      pw = if1.PWRITE; bsy = if1.busy; pa = if1.PADDR; pwd = if1.PWDATA; rrd = if1.rsp_rdata;
    end
  endtask

  task automatic model_step(input int d);
    logic [2:0]  rdy, rv, exp_rdy, new_rsp;
    logic        psel, pen, pw, bsy, found, hs;
    logic [31:0] pa, pwd, rrd;
    int          n, win, c;
    string       p;
    n = nreq[d];
    p = $sformatf("dut%0d", d);
    get_obs(d, rdy, rv, psel, pen, pw, bsy, pa, pwd, rrd);
    if (!PRESETn) begin
      chk({p, " rst_ready"}, rdy, 0);
      chk({p, " rst_psel"}, psel, 0);
      chk({p, " rst_penable"}, pen, 0);
      chk({p, " rst_busy"}, bsy, 0);
      chk({p, " rst_rsp_valid"}, rv, 0);
    end else begin
      chk({p, " psel"}, psel, m_age[d] >= 0);
      chk({p, " penable"}, pen, m_age[d] == 1);
      chk({p, " busy"}, bsy, m_age[d] >= 0);
      chk({p, " pwrite"}, pw, m_w[d]);
      chk({p, " paddr"}, pa, m_addr[d]);
      chk({p, " pwdata"}, pwd, m_wd[d]);
      chk({p, " rsp_valid"}, rv, m_rsp[d]);
      chk({p, " rsp_rdata"}, rrd, m_rd[d]);
      found = 1'b0;
      win   = 0;
      for (int k = 1; k <= n; k++) begin
        c = (m_ptr[d] + k) % n;
        if (!found && v[c]) begin
          found = 1'b1;
          win   = c;
        end
      end
      hs      = found && (m_age[d] < 0 || m_age[d] == 1);
      exp_rdy = hs ? (3'b001 << win) : 3'b000;
      chk({p, " req_ready"}, rdy, exp_rdy);
      new_rsp = '0;
      if (m_age[d] == 1) begin
        new_rsp = 3'b001 << m_idx[d];
        m_rd[d] = m_w[d] ? 32'h0 : prd;
      end
      if (m_age[d] == 0) m_age[d] = 1;
      else if (m_age[d] == 1) m_age[d] = -1;
      if (hs) begin
        m_w[d]    = w[win];
        m_addr[d] = a[win];
        m_wd[d]   = wd[win];
        m_idx[d]  = win;
        m_ptr[d]  = win;
        m_age[d]  = 0;
      end
      m_rsp[d] = new_rsp;
    end
  endtask

  // Called at a falling edge with inputs already applied; returns at the next falling edge.
  task automatic tick();
    #1;
    model_step(0);
    model_step(1);
    if (!PRESETn) model_reset();
    @(posedge PCLK);
    @(negedge PCLK);
  endtask

  task automatic async_reset();
    #2 PRESETn = 1'b0;
    #1;
    chk("async psel0", if0.PSEL, 0);
    chk("async penable0", if0.PENABLE, 0);
    chk("async busy0", if0.busy, 0);
    chk("async ready0", if0.req_ready, 0);
    chk("async rsp0", if0.rsp_valid, 0);
    chk("async psel1", if1.PSEL, 0);
    chk("async ready1", if1.req_ready, 0);
    @(posedge PCLK);
    @(negedge PCLK);
    model_reset();
    PRESETn = 1'b1;
  endtask

  task automatic randomize_inputs();
    v   = 3'($urandom_range(7));
    w   = 3'($urandom_range(7));
    prd = $urandom;
    for (int i = 0; i < 3; i++) begin
      a[i]  = $urandom;
      wd[i] = $urandom;
    end
  endtask

  logic [1:0] t4_ready [8];

  initial begin
    nreq[0] = 2;
    nreq[1] = 3;
    v = '0; w = '0; prd = '0;
    for (int i = 0; i < 3; i++) begin
      a[i] = '0; wd[i] = '0;
    end
    t4_ready = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    model_reset();
    @(negedge PCLK);
    v = 3'b111;
    tick();
    v = '0;
    PRESETn = 1'b1;

    // Reset mid-stream with every requester asserting valid.
    for (int i = 0; i < 20; i++) begin
      randomize_inputs();
      tick();
    end
    v = 3'b111;
    async_reset();
    #1;
    chk("t1 first grant dut0", if0.req_ready, 2'b01);
    chk("t1 first grant dut1", if1.req_ready, 3'b001);
    tick();
    v = '0;
    repeat (4) tick();

    // Single write from requester 0.
    v = 3'b001; w = 3'b001; a[0] = 32'h10; wd[0] = 32'hDEADBEEF;
    #1 chk("t2 ready", if0.req_ready, 2'b01);
    tick();
    v = '0;
    #1;
    chk("t2 setup psel", if0.PSEL, 1);
    chk("t2 setup penable", if0.PENABLE, 0);
    chk("t2 pwrite", if0.PWRITE, 1);
    chk("t2 paddr", if0.PADDR, 32'h10);
    chk("t2 pwdata", if0.PWDATA, 32'hDEADBEEF);
    tick();
    #1 chk("t2 access penable", if0.PENABLE, 1);
    tick();
    #1;
    chk("t2 rsp_valid", if0.rsp_valid, 2'b01);
    chk("t2 rsp_rdata", if0.rsp_rdata, 0);
    tick();

    // Single read from requester 1.
    v = 3'b010; w = 3'b000; a[1] = 32'h04;
    #1 chk("t3 ready", if0.req_ready, 2'b10);
    tick();
    v = '0;
    #1 chk("t3 setup pwrite", if0.PWRITE, 0);
    tick();
    prd = 32'h12345678;
    #1 chk("t3 access pwrite", if0.PWRITE, 0);
    tick();
    prd = '0;
    #1;
    chk("t3 rsp_valid", if0.rsp_valid, 2'b10);
    chk("t3 rsp_rdata", if0.rsp_rdata, 32'h12345678);
    tick();

    // Two requesters valid continuously: alternating grants, no idle gap.
    v = 3'b011; w = 3'b011;
    for (int k = 0; k < 8; k++) begin
      a[0] = 32'h100 + k; a[1] = 32'h200 + k;
      #1;
      chk($sformatf("t4 ready k%0d", k), if0.req_ready, t4_ready[k]);
      if (k >= 1) chk($sformatf("t4 psel k%0d", k), if0.PSEL, 1);
      tick();
    end
    v = '0;
    repeat (4) tick();

    // Reset during the ACCESS of a requester-1 read; reissue afterwards.
    v = 3'b010; w = 3'b000; a[1] = 32'h20;
    #1 chk("t5 ready", if0.req_ready, 2'b10);
    tick();
    v = '0;
    tick();
    #1 chk("t5 in access", if0.PENABLE, 1);
    async_reset();
    #1 chk("t5 no rsp after reset", if0.rsp_valid, 0);
    tick();
    #1 chk("t5 still no rsp", if0.rsp_valid, 0);
    v = 3'b010;
    #1 chk("t5 reissue ready", if0.req_ready, 2'b10);
    tick();
    v = '0;
    #1;
    chk("t5 fresh setup psel", if0.PSEL, 1);
    chk("t5 fresh setup penable", if0.PENABLE, 0);
    chk("t5 fresh paddr", if0.PADDR, 32'h20);
    repeat (4) tick();

    // Three requesters: lone req2, then req0 and req2 together.
    v = 3'b100; w = 3'b000; a[2] = 32'h30;
    #1 chk("t6 grant2", if1.req_ready, 3'b100);
    tick();
    v = 3'b101;
    #1 chk("t6 setup no ready", if1.req_ready, 3'b000);
    tick();
    #1 chk("t6 grant0 next", if1.req_ready, 3'b001);
    tick();
    tick();
    #1 chk("t6 then grant2", if1.req_ready, 3'b100);
    tick();
    v = '0;
    repeat (4) tick();

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      if ($urandom_range(99) == 0) async_reset();
      else tick();
    end
    v = '0;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
